// File: rtl/pipo_sched_pkg.sv
// Shared types and constants for the PIPO load scheduler.
package pipo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int HOLD_CNT_W = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic             found;
    logic [IDX_W-1:0] idx;
    int               sum;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        sum    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pipo_load_scheduler.sv
// Round-robin load scheduler for one shared PIPO register with a settle gap after each load.
// Optional feature: define SKIP_SAME_EN to suppress reg_en when the byte equals the last load.
module pipo_load_scheduler
    import pipo_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*WIDTH-1:0]        data_in,
    output logic [N_REQ-1:0]              ack,
    output logic                          reg_en,
    output logic [WIDTH-1:0]              reg_data,
    output logic [idx_width(N_REQ)-1:0]   grant_id,
    output logic                          busy
);

    localparam int IDX_W = idx_width(N_REQ);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic [WIDTH-1:0]      reg_data_q, reg_data_d;
    logic                  reg_en_q, reg_en_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic                  busy_q, busy_d;

    logic [IDX_W-1:0]      winner;
    logic                  any_req;
    logic [WIDTH-1:0]      sel_data;

`ifdef SKIP_SAME_EN
    logic [WIDTH-1:0]      shadow_q, shadow_d;
    logic                  shadow_vld_q, shadow_vld_d;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign sel_data = data_in[winner*WIDTH +: WIDTH];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        reg_data_d = reg_data_q;
        reg_en_d   = 1'b0;
        ack_d      = '0;
        busy_d     = busy_q;
`ifdef SKIP_SAME_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (any_req) begin
                    state_d    = LOAD;
                    grant_id_d = winner;
                    reg_data_d = sel_data;
                    ptr_d      = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    ack_d      = N_REQ'(1) << winner;
                    busy_d     = 1'b1;
`ifdef SKIP_SAME_EN
                    reg_en_d     = !(shadow_vld_q && (sel_data == shadow_q));
                    shadow_d     = sel_data;
                    shadow_vld_d = 1'b1;
`else
                    reg_en_d   = 1'b1;
`endif
                end
            end
            LOAD: begin
                if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = HOLD;
                    cnt_d   = HOLD_CNT_W'(HOLD_CYCLES - 1);
                    busy_d  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_id_q <= '0;
            reg_data_q <= '0;
            reg_en_q   <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_id_q <= grant_id_d;
            reg_data_q <= reg_data_d;
            reg_en_q   <= reg_en_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SKIP_SAME_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end
`endif

    assign ack      = ack_q;
    assign reg_en   = reg_en_q;
    assign reg_data = reg_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pipo_load_scheduler.sv
// Directed bench: one scheduler with a 2-cycle settle gap, one with no gap.
module tb_pipo_load_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  ack;
    logic        reg_en;
    logic [7:0]  reg_data;
    logic [1:0]  grant_id;
    logic        busy;

    logic [3:0]  req0 = '0;
    logic [31:0] data0 = '0;
    logic [3:0]  ack0;
    logic        reg_en0;
    logic [7:0]  reg_data0;
    logic [1:0]  grant_id0;
    logic        busy0;

    logic [7:0]  reg_out;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    pipo_load_scheduler #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .reg_en   (reg_en),
        .reg_data (reg_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    pipo_load_scheduler #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .req      (req0),
        .data_in  (data0),
        .ack      (ack0),
        .reg_en   (reg_en0),
        .reg_data (reg_data0),
        .grant_id (grant_id0),
        .busy     (busy0)
    );

    // Downstream shared register driven by the first scheduler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) reg_out <= '0;
        else if (reg_en) reg_out <= reg_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy == 1'b0) break;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] t3_bytes [4];
        logic       any_en;
        int         exp_id;
        t3_bytes[0] = 8'h10;
        t3_bytes[1] = 8'h21;
        t3_bytes[2] = 8'h32;
        t3_bytes[3] = 8'h43;

        // Reset state
        step();
        step();
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_reg_data", 32'(reg_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reg_en0", 32'(reg_en0), 32'd0);
        rst = 1'b0;
        step();

        // Test 1: reset asserted during LOAD
        req = 4'b0100;
        data_in[2*8 +: 8] = 8'h11;
        step();
        chk("t1_load_en", 32'(reg_en), 32'd1);
        chk("t1_load_ack", 32'(ack), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_en", 32'(reg_en), 32'd0);
        chk("t1_rst_ack", 32'(ack), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        req = 4'b0001;
        data_in[0 +: 8] = 8'h22;
        step();
        rst = 1'b0;
        step();
        chk("t1_after_en", 32'(reg_en), 32'd1);
        chk("t1_after_ack", 32'(ack), 32'h1);
        chk("t1_after_gid", 32'(grant_id), 32'd0);
        chk("t1_after_data", 32'(reg_data), 32'h22);
        req = '0;
        wait_idle("t1_idle");

        // Test 2: single request, latency and register capture
        req = 4'b0100;
        data_in[2*8 +: 8] = 8'hA5;
        step();
        chk("t2_en", 32'(reg_en), 32'd1);
        chk("t2_ack", 32'(ack), 32'h4);
        chk("t2_data", 32'(reg_data), 32'hA5);
        chk("t2_gid", 32'(grant_id), 32'd2);
        chk("t2_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        chk("t2_reg_out", 32'(reg_out), 32'hA5);
        chk("t2_en_off", 32'(reg_en), 32'd0);
        chk("t2_ack_off", 32'(ack), 32'd0);
        chk("t2_hold_busy", 32'(busy), 32'd1);
        wait_idle("t2_idle");

        // Test 3: all requesters, round-robin order with 4-cycle spacing
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) data_in[i*8 +: 8] = t3_bytes[i];
        req = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            step();
            chk("t3_en", 32'(reg_en), 32'((c % 4) == 1));
            chk("t3_en_vs_ack", 32'(reg_en), 32'(|ack));
            if ((c % 4) == 1) begin
                exp_id = ((c - 1) / 4) % 4;
                chk("t3_gid", 32'(grant_id), 32'(exp_id));
                chk("t3_ack", 32'(ack), 32'(4'b0001 << exp_id));
                chk("t3_data", 32'(reg_data), 32'(t3_bytes[exp_id]));
            end
        end
        req = '0;
        wait_idle("t3_idle");

        // Test 4: request dropped after grant; captured byte still loads
        req = 4'b0010;
        data_in[1*8 +: 8] = 8'h5B;
        step();
        chk("t4_en", 32'(reg_en), 32'd1);
        chk("t4_ack", 32'(ack), 32'h2);
        chk("t4_data", 32'(reg_data), 32'h5B);
        req = '0;
        data_in[1*8 +: 8] = 8'hFF;
        step();
        chk("t4_reg_out", 32'(reg_out), 32'h5B);
        any_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            any_en = any_en | reg_en;
        end
        chk("t4_no_regrant", 32'(any_en), 32'd0);

        // Test 5: zero settle gap, two requesters continuously
        data0[0 +: 8] = 8'h01;
        data0[8 +: 8] = 8'h02;
        req0 = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_id = ((c - 1) / 2) % 2;
            chk("t5_en", 32'(reg_en0), 32'((c % 2) == 1));
            chk("t5_gid", 32'(grant_id0), 32'(exp_id));
            chk("t5_data", 32'(reg_data0), 32'(exp_id + 1));
            chk("t5_ack", 32'(ack0), ((c % 2) == 1) ? 32'(4'b0001 << exp_id) : 32'd0);
        end
        req0 = '0;

        // Test 6: same byte loaded twice, then a different byte
        req = 4'b0001;
        data_in[0 +: 8] = 8'h3C;
        step();
        chk("t6_first_ack", 32'(ack), 32'h1);
        chk("t6_first_en", 32'(reg_en), 32'd1);
        req = '0;
        wait_idle("t6_idle_a");
        req = 4'b0001;
        step();
        chk("t6_second_ack", 32'(ack), 32'h1);
`ifdef SKIP_SAME_EN
        chk("t6_second_en", 32'(reg_en), 32'd0);
`else
        chk("t6_second_en", 32'(reg_en), 32'd1);
`endif
        chk("t6_second_gid", 32'(grant_id), 32'd0);
        req = '0;
        wait_idle("t6_idle_b");
        data_in[0 +: 8] = 8'h3D;
        req = 4'b0001;
        step();
        chk("t6_third_ack", 32'(ack), 32'h1);
        chk("t6_third_en", 32'(reg_en), 32'd1);
        req = '0;
        step();
        chk("t6_reg_out", 32'(reg_out), 32'h3D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
